// File: rtl/inertial_interface.sv
// -----------------------------------------------------------------------------
// inertial_interface
//
// Producer side of the inertial data path. After reset it waits INIT_WAIT
// clocks for the IMU to boot, then writes four configuration registers through
// an external 16-bit SPI master. After that it reads pitch rate and Z
// acceleration (low byte first, then high byte) on every IMU data-ready
// interrupt. It presents the results as 16-bit words together with a
// one-cycle vld pulse.
//
// SPI master handshake:
//   wrt is a one-cycle request. It is raised only in the first cycle of a
//   CFG/RD state and only when no transfer is outstanding. cmd stays constant
//   from the wrt cycle until done is sampled high. done is taken into account
//   only while a transfer is outstanding (r_busy), so a done pulse with no
//   transfer outstanding is ignored. This includes a late done from a transfer
//   that was cut off by reset. rd_data[7:0] is captured in the done cycle.
//
// Ports:
//   clk      in   1   system clock
//   rst_n    in   1   synchronous active-low reset
//   INT      in   1   IMU data-ready interrupt (asynchronous, active high)
//   done     in   1   SPI master transaction complete (1-cycle pulse)
//   rd_data  in   16  SPI master read data, valid while done is high
//   wrt      out  1   start SPI transaction (1-cycle pulse)
//   cmd      out  16  SPI command word
//   vld      out  1   new ptch_rt/AZ available (1-cycle pulse)
//   ptch_rt  out  16  pitch rate {hi,lo}, raw two's complement
//   AZ       out  16  Z acceleration {hi,lo}, raw two's complement
//   o_state  out  4   current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module inertial_interface #(
    parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        S_WAIT  = 4'd0,
        S_CFG0  = 4'd1,
        S_CFG1  = 4'd2,
        S_CFG2  = 4'd3,
        S_CFG3  = 4'd4,
        S_IDLE  = 4'd5,
        S_RD_PL = 4'd6,
        S_RD_PH = 4'd7,
        S_RD_AL = 4'd8,
        S_RD_AH = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic [15:0] r_wait_cnt;
    logic        r_int_s1;
    logic        r_int_s2;
    logic        r_int_s3;
    logic        r_pend;
    logic        r_busy;
    logic [7:0]  r_pl;
    logic [7:0]  r_ph;
    logic [7:0]  r_al;
    logic [15:0] r_ptch;
    logic [15:0] r_az;

    logic        w_int_rise;
    logic        w_xfer;
    logic        w_xfer_done;
    logic        w_in_init;
    logic        w_launch;
    logic [15:0] w_cmd;
    logic        w_unused_rd_hi;

    // Only the low byte of each SPI read carries register data.
    assign w_unused_rd_hi = ^rd_data[15:8];

    assign w_int_rise  = r_int_s2 & ~r_int_s3;
    assign w_xfer_done = r_busy & done;
    assign w_launch    = (r_state == S_IDLE) & (r_pend | w_int_rise);

    // Next-state, command decode and the flags that depend on the state.
    always_comb begin
        w_nxt_state = r_state;
        w_cmd       = 16'h0000;
        w_xfer      = 1'b0;
        w_in_init   = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_in_init = 1'b1;
                if (r_wait_cnt == INIT_WAIT) w_nxt_state = S_CFG0;
            end
            S_CFG0: begin
                w_in_init = 1'b1;
                w_xfer    = 1'b1;
                w_cmd     = 16'h0D02;   // INT on data ready
                if (w_xfer_done) w_nxt_state = S_CFG1;
            end
            S_CFG1: begin
                w_in_init = 1'b1;
                w_xfer    = 1'b1;
                w_cmd     = 16'h1053;   // accel 208Hz +/-2g
                if (w_xfer_done) w_nxt_state = S_CFG2;
            end
            S_CFG2: begin
                w_in_init = 1'b1;
                w_xfer    = 1'b1;
                w_cmd     = 16'h1150;   // gyro 208Hz 245dps
                if (w_xfer_done) w_nxt_state = S_CFG3;
            end
            S_CFG3: begin
                w_in_init = 1'b1;
                w_xfer    = 1'b1;
                w_cmd     = 16'h1460;   // rounding on
                if (w_xfer_done) w_nxt_state = S_IDLE;
            end
            S_IDLE: begin
                if (w_launch) w_nxt_state = S_RD_PL;
            end
            S_RD_PL: begin
                w_xfer = 1'b1;
                w_cmd  = 16'hA200;
                if (w_xfer_done) w_nxt_state = S_RD_PH;
            end
            S_RD_PH: begin
                w_xfer = 1'b1;
                w_cmd  = 16'hA300;
                if (w_xfer_done) w_nxt_state = S_RD_AL;
            end
            S_RD_AL: begin
                w_xfer = 1'b1;
                w_cmd  = 16'hAC00;
                if (w_xfer_done) w_nxt_state = S_RD_AH;
            end
            S_RD_AH: begin
                w_xfer = 1'b1;
                w_cmd  = 16'hAD00;
                if (w_xfer_done) w_nxt_state = S_DONE;
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_WAIT;
            end
        endcase
    end

    // Every transfer state is left through a done. Because of that, r_busy is
    // clear on entry, and wrt fires exactly once: in the entry cycle.
    assign wrt     = w_xfer & ~r_busy;
    assign cmd     = w_cmd;
    assign vld     = (r_state == S_DONE);
    assign ptch_rt = r_ptch;
    assign AZ      = r_az;
    assign o_state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 16'h0000;
            r_int_s1   <= 1'b0;
            r_int_s2   <= 1'b0;
            r_int_s3   <= 1'b0;
            r_pend     <= 1'b0;
            r_busy     <= 1'b0;
            r_pl       <= 8'h00;
            r_ph       <= 8'h00;
            r_al       <= 8'h00;
            r_ptch     <= 16'h0000;
            r_az       <= 16'h0000;
        end else begin
            r_state  <= w_nxt_state;
            r_int_s1 <= INT;
            r_int_s2 <= r_int_s1;
            r_int_s3 <= r_int_s2;

            if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 16'd1;

            if (wrt)              r_busy <= 1'b1;
            else if (w_xfer_done) r_busy <= 1'b0;

            // Interrupts are not meaningful until the IMU is configured.
            // Launching a read consumes the pending request. Any further edges
            // that arrive before the next launch collapse into one request.
            if (w_in_init || w_launch) r_pend <= 1'b0;
            else if (w_int_rise)       r_pend <= 1'b1;

            if (w_xfer_done) begin
                case (r_state)
                    S_RD_PL: r_pl <= rd_data[7:0];
                    S_RD_PH: r_ph <= rd_data[7:0];
                    S_RD_AL: r_al <= rd_data[7:0];
                    // The high AZ byte goes straight into the output word.
                    // This makes both words valid in the same cycle that vld
                    // (the DONE state) is high.
                    S_RD_AH: begin
                        r_ptch <= {r_ph, r_pl};
                        r_az   <= {rd_data[7:0], r_al};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inertial_interface.sv
module tb_inertial_interface;

    localparam logic [15:0] INIT_WAIT = 16'd16;
    localparam logic [3:0]  ST_WAIT   = 4'd0;
    localparam logic [3:0]  ST_CFG1   = 4'd2;
    localparam logic [3:0]  ST_IDLE   = 4'd5;
    localparam logic [3:0]  ST_RD_PH  = 4'd7;
    localparam logic [3:0]  ST_RD_AL  = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_in;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] az;
    logic [3:0]  state;

    // Scoreboard: the stimulus pushes expected commands and results here.
    logic [15:0] exp_cmd_q[$];
    logic [31:0] exp_vld_q[$];

    // Bytes that the SPI model returns for each read register.
    logic [7:0]  b_pl, b_ph, b_al, b_ah;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wrt    = 0;
    int n_vld    = 0;
    int n_overlap   = 0;
    int n_unstable  = 0;
    int n_vld_long  = 0;
    int cyc         = 0;
    int done_ah_cyc = -1;

    inertial_interface #(.INIT_WAIT(INIT_WAIT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (int_in),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (az),
        .o_state (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- SPI master model ----------------
    // done is driven on the falling edge, so the DUT sees it at exactly one
    // rising edge. The upper byte of rd_data is random junk.
    logic [15:0] rsp_cmd;
    logic [7:0]  rsp_byte;
    initial begin
        done    = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (wrt === 1'b1 && rst_n === 1'b1) begin
                rsp_cmd = cmd;
                repeat ($urandom_range(2, 5)) @(negedge clk);
                case (rsp_cmd)
                    16'hA200: rsp_byte = b_pl;
                    16'hA300: rsp_byte = b_ph;
                    16'hAC00: rsp_byte = b_al;
                    16'hAD00: rsp_byte = b_ah;
                    default:  rsp_byte = 8'h00;
                endcase
                rd_data = {8'($urandom_range(0, 255)), rsp_byte};
                done    = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard compare ----------------
    logic        outstanding = 1'b0;
    logic [15:0] cur_cmd     = 16'h0000;
    logic        prev_vld    = 1'b0;
    logic [15:0] e_cmd;
    logic [31:0] e_vld;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n !== 1'b1) begin
                outstanding = 1'b0;
            end else begin
                if (outstanding) begin
                    if (done === 1'b1) begin
                        outstanding = 1'b0;
                        if (cur_cmd == 16'hAD00) done_ah_cyc = cyc;
                    end else if (cmd !== cur_cmd) begin
                        n_unstable++;
                    end
                end
                if (wrt === 1'b1) begin
                    n_wrt++;
                    if (outstanding) n_overlap++;
                    outstanding = 1'b1;
                    cur_cmd     = cmd;
                    n_checks++;
                    if (exp_cmd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wrt_cmd: got unexpected cmd %h, required no wrt", cmd);
                    end else begin
                        e_cmd = exp_cmd_q.pop_front();
                        if (cmd !== e_cmd) begin
                            n_fail++;
                            $display("FAIL wrt_cmd: got %h, required %h", cmd, e_cmd);
                        end
                    end
                end
                if (vld === 1'b1) begin
                    n_vld++;
                    if (prev_vld) n_vld_long++;
                    n_checks++;
                    if (exp_vld_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL vld_data: got unexpected vld ptch=%h az=%h", ptch_rt, az);
                    end else begin
                        e_vld = exp_vld_q.pop_front();
                        if ({ptch_rt, az} !== e_vld) begin
                            n_fail++;
                            $display("FAIL vld_data: got ptch=%h az=%h, required ptch=%h az=%h",
                                     ptch_rt, az, e_vld[31:16], e_vld[15:0]);
                        end
                    end
                    // done is high during the cycle before the edge and vld
                    // during the cycle after it, so the post-edge sample sees
                    // both at once.
                    n_checks++;
                    if (cyc !== done_ah_cyc) begin
                        n_fail++;
                        $display("FAIL vld_latency: vld sample %0d, AD00 done sample %0d", cyc, done_ah_cyc);
                    end
                end
            end
            prev_vld = vld;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_int(input int hi);
        @(negedge clk);
        int_in = 1'b1;
        repeat (hi) @(negedge clk);
        int_in = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #1;
            if (state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_init_cmds();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    task automatic push_read(input logic [7:0] pl, ph, al, ah);
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
        exp_vld_q.push_back({ph, pl, ah, al});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        int_in = 1'b0;
        b_pl = 8'h00; b_ph = 8'h00; b_al = 8'h00; b_ah = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wrt !== 1'b0)        begin n_fail++; $display("FAIL reset_wrt: got %b, required 0", wrt); end
        n_checks++; if (cmd !== 16'h0000)    begin n_fail++; $display("FAIL reset_cmd: got %h, required 0000", cmd); end
        n_checks++; if (vld !== 1'b0)        begin n_fail++; $display("FAIL reset_vld: got %b, required 0", vld); end
        n_checks++; if (ptch_rt !== 16'h0)   begin n_fail++; $display("FAIL reset_ptch: got %h, required 0000", ptch_rt); end
        n_checks++; if (az !== 16'h0)        begin n_fail++; $display("FAIL reset_az: got %h, required 0000", az); end
        n_checks++; if (state !== ST_WAIT)   begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", state, ST_WAIT); end
    endtask

    task automatic test_init();
        int first;
        bit ok;
        push_init_cmds();
        @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (wrt === 1'b1) begin
                first = k;
                break;
            end
        end
        // The counter runs 0..INIT_WAIT in WAIT, so the first wrt is seen after
        // INIT_WAIT+1 rising edges.
        n_checks++; if (first !== 17) begin n_fail++; $display("FAIL init_first_wrt: at edge %0d, required 17", first); end
        wait_state(ST_IDLE, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL init_idle: state %0d, required %0d", state, ST_IDLE); end
        n_checks++; if (exp_cmd_q.size() != 0) begin n_fail++; $display("FAIL init_cmds: %0d cmds not seen, required 0", exp_cmd_q.size()); end
        n_checks++; if (n_overlap != 0 || n_unstable != 0) begin
            n_fail++; $display("FAIL init_handshake: overlap=%0d unstable=%0d, required 0/0", n_overlap, n_unstable);
        end
    endtask

    task automatic test_read(input logic [7:0] pl, ph, al, ah, input logic [31:0] want, input string name);
        int v0;
        bit ok;
        b_pl = pl; b_ph = ph; b_al = al; b_ah = ah;
        push_read(pl, ph, al, ah);
        v0 = n_vld;
        pulse_int(3);
        for (int k = 0; k < 300 && n_vld == v0; k++) begin
            @(posedge clk);
            #1;
        end
        n_checks++; if (n_vld != v0 + 1) begin n_fail++; $display("FAIL %s_vld: %0d pulses, required 1", name, n_vld - v0); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if ({ptch_rt, az} !== want) begin
            n_fail++; $display("FAIL %s_hold: ptch=%h az=%h, required ptch=%h az=%h", name, ptch_rt, az, want[31:16], want[15:0]);
        end
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL %s_vld_low: got %b, required 0", name, vld); end
        wait_state(ST_IDLE, 50, ok);
        n_checks++; if (!ok || exp_cmd_q.size() != 0 || exp_vld_q.size() != 0) begin
            n_fail++; $display("FAIL %s_drain: state %0d cmds %0d vlds %0d left, required IDLE/0/0", name, state, exp_cmd_q.size(), exp_vld_q.size());
        end
        n_checks++; if (n_vld_long != 0 || n_overlap != 0) begin
            n_fail++; $display("FAIL %s_pulses: long_vld=%0d overlap=%0d, required 0/0", name, n_vld_long, n_overlap);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        bit ok;
        b_pl = 8'h11; b_ph = 8'h22; b_al = 8'h33; b_ah = 8'h44;
        push_read(8'h11, 8'h22, 8'h33, 8'h44);
        push_read(8'h11, 8'h22, 8'h33, 8'h44);
        v0 = n_vld;
        pulse_int(3);
        wait_state(ST_RD_PH, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_rd_ph: state %0d, required %0d", state, ST_RD_PH); end
        pulse_int(2);
        for (int k = 0; k < 400 && n_vld < v0 + 2; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (n_vld != v0 + 2) begin n_fail++; $display("FAIL b2b_count: %0d vld pulses, required 2", n_vld - v0); end
        n_checks++; if (state !== ST_IDLE || exp_cmd_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: state %0d cmds left %0d, required IDLE/0", state, exp_cmd_q.size());
        end
    endtask

    task automatic test_int_during_init();
        int v0, w0;
        bit ok;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push_init_cmds();
        rst_n = 1'b1;
        pulse_int(2);
        wait_state(ST_CFG1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL initint_cfg1: state %0d, required %0d", state, ST_CFG1); end
        pulse_int(1);
        wait_state(ST_IDLE, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL initint_idle: state %0d, required %0d", state, ST_IDLE); end
        v0 = n_vld;
        w0 = n_wrt;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (n_vld != v0 || n_wrt != w0) begin
            n_fail++; $display("FAIL initint_no_read: %0d vld %0d wrt after init, required 0/0", n_vld - v0, n_wrt - w0);
        end
        n_checks++; if (exp_cmd_q.size() != 0) begin n_fail++; $display("FAIL initint_cmds: %0d left, required 0", exp_cmd_q.size()); end
    endtask

    task automatic test_reset_mid();
        int w0;
        bit ok;
        b_pl = 8'h9A; b_ph = 8'hBC; b_al = 8'hDE; b_ah = 8'hF0;
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        pulse_int(3);
        wait_state(ST_RD_AL, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_rd_al: state %0d, required %0d", state, ST_RD_AL); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if ({wrt, vld} !== 2'b00 || cmd !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_ctrl: wrt=%b vld=%b cmd=%h, required 0/0/0000", wrt, vld, cmd);
        end
        n_checks++; if (ptch_rt !== 16'h0 || az !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_data: ptch=%h az=%h, required 0000/0000", ptch_rt, az);
        end
        n_checks++; if (state !== ST_WAIT) begin n_fail++; $display("FAIL rstmid_state: got %0d, required %0d", state, ST_WAIT); end
        push_init_cmds();
        @(negedge clk);
        rst_n = 1'b1;
        w0 = n_wrt;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (n_wrt != w0) begin n_fail++; $display("FAIL rstmid_stray_done: %0d wrt in WAIT, required 0", n_wrt - w0); end
        wait_state(ST_IDLE, 300, ok);
        n_checks++; if (!ok || exp_cmd_q.size() != 0 || exp_vld_q.size() != 0) begin
            n_fail++; $display("FAIL rstmid_reinit: state %0d cmds %0d vlds %0d left, required IDLE/0/0", state, exp_cmd_q.size(), exp_vld_q.size());
        end
        n_checks++; if (n_overlap != 0 || n_unstable != 0) begin
            n_fail++; $display("FAIL rstmid_handshake: overlap=%0d unstable=%0d, required 0/0", n_overlap, n_unstable);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read(8'h34, 8'h12, 8'h78, 8'h56, 32'h1234_5678, "read_pos");
        test_read(8'h00, 8'hFC, 8'h80, 8'hFE, 32'hFC00_FE80, "read_neg");
        test_back_to_back();
        test_int_during_init();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inertial_interface.md
Name: inertial_interface

Overview:
- Producer side of the inertial data path. Configures the IMU over SPI after reset.
- On each IMU data-ready interrupt, reads pitch rate and Z acceleration, assembles them into 16-bit words, and pulses vld.
- Feeds the pitch integrator's vld / ptch_rt / AZ inputs.
- Drives an existing 16-bit SPI master through its wrt/cmd/done/rd_data handshake. Does not generate SCLK/MOSI itself.

Parameters:
- INIT_WAIT, 16'hFFFF, post-reset wait in clk cycles before the first SPI write (IMU boot time); benches use a small value.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- INT  input  1  IMU data-ready interrupt, asynchronous, active high
- done  input  1  SPI master transaction-complete pulse, 1 cycle
- rd_data  input  16  SPI master read data; valid in the cycle done is high
- wrt  output  1  start SPI transaction, 1-cycle pulse
- cmd  output  16  SPI command word; held stable from wrt until done
- vld  output  1  new ptch_rt/AZ available, 1-cycle pulse
- ptch_rt  output  16  pitch rate {hi,lo}, raw two's complement
- AZ  output  16  Z acceleration {hi,lo}, raw two's complement

Behaviour:
- Reset: one clock domain. Reset is synchronous and active-low: rst_n sampled low at a clk edge resets all state.
  - Reset values: wrt=0, cmd=16'h0000, vld=0, ptch_rt=16'h0000, AZ=16'h0000.
  - Internal state: wait counter=0, INT synchronizer=0, pending flag=0, FSM=WAIT.
- Reset mid-transaction: abandon the transaction and return to WAIT. Ignore a late done from the aborted transfer, since the FSM in WAIT never samples done.
- INT synchronization and pending flag:
  - INT passes through two flops; a third flop provides edge detection.
  - A rising edge is (sync2 & ~sync3).
  - A rising edge sets the pending flag.
  - The pending flag clears in the cycle a read sequence launches.
  - Edges before INIT completes are discarded (flag held 0).
- FSM states: WAIT, CFG0, CFG1, CFG2, CFG3, IDLE, RD_PL, RD_PH, RD_AL, RD_AH, DONE.
  - WAIT: increment counter each cycle. When counter==INIT_WAIT, go to CFG0.
  - CFGn: on entry, pulse wrt for 1 cycle with cmd; wait for done; advance.
    - CFG0 cmd 16'h0D02: INT on data ready.
    - CFG1 cmd 16'h1053: accel 208Hz ±2g.
    - CFG2 cmd 16'h1150: gyro 208Hz 245dps.
    - CFG3 cmd 16'h1460: rounding on.
    - CFG3 done goes to IDLE.
  - IDLE: if pending flag is set (or a rising edge occurs this cycle), go to RD_PL.
  - RD_* states: same wrt/done handshake. On done, capture rd_data[7:0] into the named byte register.
    - RD_PL cmd 16'hA200: pitch rate low.
    - RD_PH cmd 16'hA300: pitch rate high.
    - RD_AL cmd 16'hAC00: AZ low.
    - RD_AH cmd 16'hAD00: AZ high.
  - DONE: load ptch_rt={PH,PL} and AZ={AH,AL}, assert vld for exactly this cycle, then go to IDLE.
- Output update rule: ptch_rt and AZ change only in the vld cycle and hold otherwise.
- Latency: vld asserts 1 cycle after the done of RD_AH.
- wrt rules:
  - Never asserted while a transaction is outstanding.
  - At most one wrt per state entry.
  - wrt asserts in the first cycle of each CFG/RD state.
- INT during a read sequence: latch it as pending; service it immediately after DONE→IDLE (one extra IDLE cycle). No interrupt is lost and none is double-counted. Multiple edges while pending collapse to one.
- done outside a transaction: ignored.

Test Plan:
- Reset with INIT_WAIT=16 → no wrt for 16 cycles. Then wrt with cmd sequence 0D02, 1063→no: 0D02, 1053, 1150, 1460, each issued only after the previous done. FSM reaches IDLE.
- After init, raise INT with SPI model returning low bytes 0x34/0x78 and high bytes 0x12/0x56 → cmds A200, A300, AC00, AD00 issued. vld=1 for one cycle with ptch_rt=16'h1234, AZ=16'h5678.
- Negative data: bytes PL=0x00, PH=0xFC, AL=0x80, AH=0xFE → ptch_rt=16'hFC00, AZ=16'hFE80. Values hold after vld drops.
- INT edge during RD_PH → current sequence completes with a single vld. A second sequence starts without a new INT, giving exactly 2 vld pulses total.
- INT pulsed during WAIT/CFG → no read sequence is started after init.
- rst_n low during RD_AL → next cycle outputs are 0 and FSM is in WAIT. A stray done afterward causes no wrt. Full init then repeats.
